noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router. It shares one 32-bit valid/ready output link between N_IN input ports.
- Grants are round-robin. The output is locked to one input from head flit to tail flit, so flits of different packets never interleave.
- Sits between the router's route-computation/input buffers and the output link toward the neighbouring node or the local node's ejection port.

Parameters:
- N_IN, 5, number of requesting input ports (4 mesh directions + local).
- DATA_WIDTH, 32, flit width.
- MAX_FLITS, 6, maximum flits per packet (head through tail). Used for the lock watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_IN*DATA_WIDTH  flit from input i, at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  N_IN  input i presents a flit routed to this output.
- in_ready  out  N_IN  flit on input i is accepted this cycle.
- out_data  out  DATA_WIDTH  flit to the downstream link.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the flit.
- grant  out  N_IN  one-hot current owner; all zero when idle.
- err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Flit type is data[DW-1:DW-2]: 01 head, 00 body, 10 tail, 11 single-flit (head+tail).
- A transfer occurs when out_valid && out_ready. It corresponds to in_valid[g] && in_ready[g] for the owner g.
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, grant=0, rr_ptr=0, flit_cnt=0, err=0.
  - out_valid=0, in_ready=0 on the following and all reset cycles.
  - A packet in flight is abandoned. The bench re-injects it.
- IDLE state:
  - out_valid=0; in_ready=0 for all inputs.
  - Candidates are inputs with in_valid=1 and flit type head or single.
  - Winner is the first candidate at or after rr_ptr, searching upward with wrap N_IN-1 -> 0.
  - On a winner: next cycle state=LOCKED, grant=onehot(winner), flit_cnt=0. Arbitration latency is 1 cycle.
  - Valid inputs presenting body/tail flits are ignored (not candidates). No err is raised.
- LOCKED state (owner g):
  - Combinational, zero-latency pass-through: out_data=in_data[g], out_valid=in_valid[g], in_ready[g]=out_ready. in_ready is 0 for all other inputs.
  - Each transfer increments flit_cnt.
  - A transfer of a tail or single flit ends the packet. Next cycle: state=IDLE, grant=0, rr_ptr=(g+1) mod N_IN.
  - Result: one idle bubble cycle between consecutive packets on the output.
  - Backpressure (out_ready=0) holds everything. flit_cnt does not advance, and the owner must hold its flit stable.
  - in_valid[g] dropping mid-packet holds the lock (out_valid=0). No timeout applies to upstream stalls.
- Watchdog:
  - Condition: a transfer of a non-tail flit brings flit_cnt to MAX_FLITS (malformed packet, missing tail).
  - Action: force release exactly as for a tail (IDLE, rr_ptr=g+1) and pulse err=1 for one cycle, aligned with grant returning to 0.
- Simultaneous events:
  - A tail transfer and a new head on another input in the same cycle: the new head is arbitrated in the following IDLE cycle, not the same cycle.
  - A single-flit packet takes 1 arbitration cycle plus 1 transfer cycle.
- flit_cnt width is clog2(MAX_FLITS+1). It never wraps.

Test Plan:
- Reset, then input 0 sends a 6-flit packet (head 0x40000001, 4 body flits, tail 0x80000006) with out_ready=1:
  - grant=00001 one cycle after the head appears.
  - 6 consecutive out transfers with identical data.
  - grant=0 the cycle after the tail; rr_ptr=1.
- Inputs 0 and 2 both present heads at reset exit:
  - Input 0 is served first, then input 2 after a 1-cycle bubble.
  - On a repeat, input 2 then input 0 win (round-robin fairness). No interleaving of their flits.
- Owner locked, out_ready low for 3 cycles mid-packet:
  - out_data and out_valid are held, in_ready[g]=0, flit_cnt frozen.
  - Transfer resumes with no flit loss or duplication.
- Single-flit packet 0xC00000AA on input 4:
  - grant=10000 for exactly 1 cycle, one transfer, then IDLE.
- Input 1 sends 6 flits, all head/body, with no tail:
  - Release after the 6th transfer; err=1 for exactly one cycle.
  - Waiting input 3 is then granted.
- rst asserted on the 3rd flit of a packet:
  - grant=0, out_valid=0, in_ready=0 next cycle.
  - After deassert, a fresh head on input 0 is granted normally.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin wormhole arbiter sharing one output link between N_IN inputs
module noc_output_arbiter #(
  parameter int N_IN       = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_FLITS  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_IN-1:0]            grant,
  output logic                       err
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FLITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  owner, owner_n;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_n;
  logic [N_IN-1:0]   grant_n;
  logic [CNT_W-1:0]  flit_cnt, flit_cnt_n;
  logic              err_n;

  logic [N_IN-1:0]   cand;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic              xfer;
  logic              is_end;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wd_fire;
  logic              release_now;

  // Only head (01) and single (11) flits may open a packet: type bit DW-2 set.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand[i] = in_valid[i] & in_data[i*DATA_WIDTH + DATA_WIDTH - 2];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_IN; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    in_ready  = '0;
    if (state == LOCKED) begin
      for (int i = 0; i < N_IN; i++) begin
        if (owner == IDX_W'(i)) begin
          out_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_valid   = in_valid[i];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  // Tail (10) and single (11) both end a packet: type bit DW-1 set.
  assign xfer        = out_valid & out_ready;
  assign is_end      = out_data[DATA_WIDTH-1];
  assign cnt_inc     = flit_cnt + 1'b1;
  assign wd_fire     = xfer & ~is_end & (cnt_inc == MAX_CNT);
  assign release_now = xfer & (is_end | wd_fire);

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    grant_n    = grant;
    flit_cnt_n = flit_cnt;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = LOCKED;
          owner_n    = win;
          grant_n    = N_IN'(1) << win;
          flit_cnt_n = '0;
        end
      end
      LOCKED: begin
        if (xfer) flit_cnt_n = cnt_inc;
        if (release_now) begin
          state_n  = IDLE;
          grant_n  = '0;
          rr_ptr_n = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          err_n    = wd_fire;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      flit_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      grant    <= grant_n;
      flit_cnt <= flit_cnt_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed self-checking bench for noc_output_arbiter
module tb_noc_output_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] in_data;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   grant;
  logic         err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pkt0 [6];
  logic [31:0] pkt1 [6];

  noc_output_arbiter #(.N_IN(5), .DATA_WIDTH(32), .MAX_FLITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int i, input logic [31:0] d);
    in_data[i*32 +: 32] = d;
    in_valid[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    in_data[i*32 +: 32] = 32'h0;
    in_valid[i] = 1'b0;
  endtask

  // Entered at the arbitration (IDLE) cycle with head h presented on input g.
  task automatic serve2(input int g, input logic [31:0] h, input logic [31:0] t);
    #1;
    chk("s2_idle_grant", 32'(grant), 32'h0);
    chk("s2_idle_valid", 32'(out_valid), 32'h0);
    tick(); #1;
    chk("s2_grant", 32'(grant), 32'(5'b1 << g));
    chk("s2_head", out_data, h);
    chk("s2_ready_head", 32'(in_ready), 32'(5'b1 << g));
    tick();
    put(g, t); #1;
    chk("s2_tail", out_data, t);
    chk("s2_ready_tail", 32'(in_ready), 32'(5'b1 << g));
    tick();
    drop(g);
  endtask

  initial begin
    pkt0[0] = 32'h40000001; pkt0[1] = 32'h00000002; pkt0[2] = 32'h00000003;
    pkt0[3] = 32'h00000004; pkt0[4] = 32'h00000005; pkt0[5] = 32'h80000006;
    pkt1[0] = 32'h40000011; pkt1[1] = 32'h00000012; pkt1[2] = 32'h00000013;
    pkt1[3] = 32'h00000014; pkt1[4] = 32'h00000015; pkt1[5] = 32'h00000016;

    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);

    // 6-flit packet on input 0
    put(0, pkt0[0]); #1;
    chk("p0_idle_valid", 32'(out_valid), 32'h0);
    chk("p0_idle_ready", 32'(in_ready), 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      put(0, pkt0[k]); #1;
      chk("p0_grant", 32'(grant), 32'h1);
      chk("p0_valid", 32'(out_valid), 32'h1);
      chk("p0_data", out_data, pkt0[k]);
      chk("p0_ready", 32'(in_ready), 32'h1);
      tick();
    end
    drop(0); #1;
    chk("p0_release_grant", 32'(grant), 32'h0);
    chk("p0_release_valid", 32'(out_valid), 32'h0);
    chk("p0_rr_ptr", 32'(dut.rr_ptr), 32'h1);
    chk("p0_err", 32'(err), 32'h0);

    // Heads on 0 and 2 at reset exit, then alternating re-requests
    rst = 1'b1; tick();
    put(0, 32'h40000A00); put(2, 32'h40000A02);
    rst = 1'b0;
    serve2(0, 32'h40000A00, 32'h80000A00);
    put(0, 32'h40000B00);
    serve2(2, 32'h40000A02, 32'h80000A02);
    put(2, 32'h40000B02);
    serve2(0, 32'h40000B00, 32'h80000B00);
    serve2(2, 32'h40000B02, 32'h80000B02);
    #1;
    chk("rr_after_fair", 32'(dut.rr_ptr), 32'h3);

    // Backpressure mid-packet on input 1
    put(1, 32'h40000021); tick(); #1;
    chk("bp_grant", 32'(grant), 32'h2);
    chk("bp_head", out_data, 32'h40000021);
    tick();
    put(1, 32'h00000022);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_data", out_data, 32'h00000022);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_ready", 32'(in_ready), 32'h0);
      chk("bp_hold_cnt", 32'(dut.flit_cnt), 32'h1);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_resume_data", out_data, 32'h00000022);
    chk("bp_resume_ready", 32'(in_ready), 32'h2);
    tick();
    put(1, 32'h00000023); #1;
    chk("bp_body2", out_data, 32'h00000023);
    chk("bp_cnt2", 32'(dut.flit_cnt), 32'h2);
    tick();
    put(1, 32'h80000024); #1;
    chk("bp_tail", out_data, 32'h80000024);
    chk("bp_cnt3", 32'(dut.flit_cnt), 32'h3);
    tick();
    drop(1); #1;
    chk("bp_release", 32'(grant), 32'h0);

    // Single-flit packet on input 4
    put(4, 32'hC00000AA); #1;
    chk("sf_idle_grant", 32'(grant), 32'h0);
    tick(); #1;
    chk("sf_grant", 32'(grant), 32'h10);
    chk("sf_data", out_data, 32'hC00000AA);
    chk("sf_ready", 32'(in_ready), 32'h10);
    tick();
    drop(4); #1;
    chk("sf_release", 32'(grant), 32'h0);
    chk("sf_valid", 32'(out_valid), 32'h0);
    chk("sf_rr_ptr", 32'(dut.rr_ptr), 32'h0);

    // Missing tail on input 1 while input 3 waits
    put(1, pkt1[0]); put(3, 32'h40000031);
    tick();
    for (int k = 0; k < 6; k++) begin
      put(1, pkt1[k]); #1;
      chk("wd_grant", 32'(grant), 32'h2);
      chk("wd_data", out_data, pkt1[k]);
      chk("wd_ready", 32'(in_ready), 32'h2);
      chk("wd_err_low", 32'(err), 32'h0);
      tick();
    end
    drop(1); #1;
    chk("wd_release_grant", 32'(grant), 32'h0);
    chk("wd_err_pulse", 32'(err), 32'h1);
    chk("wd_rr_ptr", 32'(dut.rr_ptr), 32'h2);
    tick(); #1;
    chk("wd_err_cleared", 32'(err), 32'h0);
    chk("wd_next_grant", 32'(grant), 32'h8);
    chk("wd_next_head", out_data, 32'h40000031);
    tick();
    put(3, 32'h80000032); #1;
    chk("wd_next_tail", out_data, 32'h80000032);
    tick();
    drop(3);

    // Reset on the 3rd flit of a packet on input 0
    put(0, 32'h40000041); tick();
    tick();
    put(0, 32'h00000042); tick();
    put(0, 32'h00000043);
    rst = 1'b1; #1;
    chk("mr_third", out_data, 32'h00000043);
    tick(); #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_ready", 32'(in_ready), 32'h0);
    tick(); #1;
    chk("mr_hold_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    put(0, 32'h40000077); #1;
    chk("mr_idle_grant", 32'(grant), 32'h0);
    tick(); #1;
    chk("mr_regrant", 32'(grant), 32'h1);
    chk("mr_head", out_data, 32'h40000077);
    chk("mr_head_ready", 32'(in_ready), 32'h1);
    tick();
    put(0, 32'h80000078); #1;
    chk("mr_tail", out_data, 32'h80000078);
    tick();
    drop(0); #1;
    chk("mr_done", 32'(grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
